// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit.
//   - PcSrc encodings for the next-PC select.
//   - FSM state type.
//   - Cause code raised for misaligned control-flow targets.
package pc_pkg;

  localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;
  localparam logic [1:0] PCSRC_MRET   = 2'b11;

  localparam int unsigned CAUSE_INSN_MISALIGNED = 0;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHandler,
    StHalt
  } pc_state_e;

endpackage

// File: rtl/pc_unit_if.sv
// Bus between the decode/ALU stage and the program-counter unit.
// master: the pipeline side; it drives Stall/PcSrc/Imm/ALU_Output/Trap_Req/Trap_Cause
//         and observes the PC, trap and status outputs.
// slave : the pc_unit side.
interface pc_unit_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned CAUSE_W = 4
);
  logic               Stall;
  logic [1:0]         PcSrc;
  logic [XLEN-1:0]    Imm;
  logic [XLEN-1:0]    ALU_Output;
  logic               Trap_Req;
  logic [CAUSE_W-1:0] Trap_Cause;

  logic [XLEN-1:0]    Current_pc;
  logic [XLEN-1:0]    Pc_Plus4;
  logic [XLEN-1:0]    Next_Address;
  logic               Pc_Valid;
  logic               Trap_Taken;
  logic [XLEN-1:0]    Mepc;
  logic [XLEN-1:0]    Mtval;
  logic [CAUSE_W-1:0] Mcause;
  logic               Halted;

  modport master (
    output Stall, PcSrc, Imm, ALU_Output, Trap_Req, Trap_Cause,
    input  Current_pc, Pc_Plus4, Next_Address, Pc_Valid, Trap_Taken,
           Mepc, Mtval, Mcause, Halted
  );

  modport slave (
    input  Stall, PcSrc, Imm, ALU_Output, Trap_Req, Trap_Cause,
    output Current_pc, Pc_Plus4, Next_Address, Pc_Valid, Trap_Taken,
           Mepc, Mtval, Mcause, Halted
  );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational control-flow target arithmetic and alignment check.
// Ports:
//   pc_i          current PC
//   imm_i         branch/jal offset
//   alu_i         jalr target before LSB clear
//   mepc_i        return address for mret
//   pcsrc_i       target select
//   target_o      selected target (PC+4 for PCSRC_PLUS4)
//   misaligned_o  target is not IALIGN-aligned and pcsrc_i is a redirect
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 4
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [1:0]      pcsrc_i,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  always_comb begin
    target_o = pc_i + XLEN'(4);
    case (pcsrc_i)
      PCSRC_BRANCH: target_o = pc_i + imm_i;
      PCSRC_JALR:   target_o = {alu_i[XLEN-1:1], 1'b0};
      PCSRC_MRET:   target_o = mepc_i;
      default:      target_o = pc_i + XLEN'(4);
    endcase
  end

  // With 2-byte alignment only bit 0 matters, which jalr has already cleared.
  always_comb begin
    misaligned_o = 1'b0;
    if (pcsrc_i != PCSRC_PLUS4) begin
      misaligned_o = (IALIGN == 4) ? target_o[1] : target_o[0];
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: architectural PC, next-PC selection, trap entry/mret
// and a BOOT/RUN/HANDLER/HALT state machine.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    pc_unit_if slave: pipeline controls in, PC/trap/status out
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned     IALIGN       = 4,
  parameter int unsigned     CAUSE_W      = 4
) (
  input logic        clk,
  input logic        reset,
  pc_unit_if.slave   bus
);

  pc_state_e          state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    mepc_q, mepc_d;
  logic [XLEN-1:0]    mtval_q, mtval_d;
  logic [CAUSE_W-1:0] mcause_q, mcause_d;
  logic               pc_valid_q, pc_valid_d;
  logic               halted_q, halted_d;

  logic [XLEN-1:0]    pc_plus4;
  logic [XLEN-1:0]    target;
  logic               misaligned;
  logic               misaligned_eff;
  logic               trap;

  assign pc_plus4 = pc_q + XLEN'(4);

  pc_target_calc #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_target (
    .pc_i         (pc_q),
    .imm_i        (bus.Imm),
    .alu_i        (bus.ALU_Output),
    .mepc_i       (mepc_q),
    .pcsrc_i      (bus.PcSrc),
    .target_o     (target),
    .misaligned_o (misaligned)
  );

  // mret outside the handler behaves as PC+4, so its target is never checked.
  assign misaligned_eff = misaligned && !(state_q == StRun && bus.PcSrc == PCSRC_MRET);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mepc_d   = mepc_q;
    mtval_d  = mtval_q;
    mcause_d = mcause_q;
    trap     = 1'b0;

    if (!bus.Stall) begin
      case (state_q)
        StBoot: state_d = StRun;

        StRun, StHandler: begin
          if (bus.Trap_Req) begin
            trap     = 1'b1;
            mcause_d = bus.Trap_Cause;
            mtval_d  = '0;
          end else if (misaligned_eff) begin
            trap     = 1'b1;
            mcause_d = CAUSE_W'(CAUSE_INSN_MISALIGNED);
            mtval_d  = target;
          end

          if (trap) begin
            mepc_d = pc_q;
            if (state_q == StRun) begin
              pc_d    = TRAP_VECTOR;
              state_d = StHandler;
            end else begin
              // Nested trap: record it and freeze the PC where it happened.
              state_d = StHalt;
            end
          end else begin
            case (bus.PcSrc)
              PCSRC_BRANCH, PCSRC_JALR: pc_d = target;
              PCSRC_MRET: begin
                if (state_q == StHandler) begin
                  pc_d    = mepc_q;
                  state_d = StRun;
                end else begin
                  pc_d = pc_plus4;
                end
              end
              default: pc_d = pc_plus4;
            endcase
          end
        end

        default: ; // StHalt: inputs ignored until reset
      endcase
    end

    pc_valid_d = (state_d == StRun) || (state_d == StHandler);
    halted_d   = (state_d == StHalt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StBoot;
      pc_q       <= RESET_VECTOR;
      mepc_q     <= '0;
      mtval_q    <= '0;
      mcause_q   <= '0;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mepc_q     <= mepc_d;
      mtval_q    <= mtval_d;
      mcause_q   <= mcause_d;
      pc_valid_q <= pc_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign bus.Current_pc   = pc_q;
  assign bus.Pc_Plus4     = pc_plus4;
  assign bus.Next_Address = pc_d;
  assign bus.Pc_Valid     = pc_valid_q;
  assign bus.Trap_Taken   = trap;
  assign bus.Mepc         = mepc_q;
  assign bus.Mtval        = mtval_q;
  assign bus.Mcause       = mcause_q;
  assign bus.Halted       = halted_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pc_unit_if #(.XLEN(32), .CAUSE_W(4)) bus ();

  pc_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100),
    .IALIGN       (4),
    .CAUSE_W      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Stall      = 1'b0;
    bus.PcSrc      = 2'b00;
    bus.Imm        = '0;
    bus.ALU_Output = '0;
    bus.Trap_Req   = 1'b0;
    bus.Trap_Cause = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (bus.Current_pc !== 32'h0) begin errors++;
      $display("FAIL rst_pc: got %h want %h", bus.Current_pc, 32'h0); end
    checks++; if (bus.Pc_Valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid: got %b want 0", bus.Pc_Valid); end
    checks++; if (bus.Halted !== 1'b0) begin errors++;
      $display("FAIL rst_halted: got %b want 0", bus.Halted); end
    checks++; if ({bus.Mepc, bus.Mtval, bus.Mcause} !== 68'h0) begin errors++;
      $display("FAIL rst_mregs: got %h %h %h want 0 0 0", bus.Mepc, bus.Mtval, bus.Mcause); end
    reset = 1'b0;
    #1;
    checks++; if (bus.Next_Address !== 32'h0) begin errors++;
      $display("FAIL boot_next: got %h want %h", bus.Next_Address, 32'h0); end
    tick();
    checks++; if (bus.Current_pc !== 32'h0 || bus.Pc_Valid !== 1'b1) begin errors++;
      $display("FAIL boot_run: got pc=%h v=%b want pc=0 v=1", bus.Current_pc, bus.Pc_Valid); end
    tick();
    checks++; if (bus.Current_pc !== 32'h4) begin errors++;
      $display("FAIL run_pc4: got %h want %h", bus.Current_pc, 32'h4); end
    tick();
    checks++; if (bus.Current_pc !== 32'h8) begin errors++;
      $display("FAIL run_pc8: got %h want %h", bus.Current_pc, 32'h8); end
    checks++; if (bus.Pc_Plus4 !== 32'hC) begin errors++;
      $display("FAIL pc_plus4: got %h want %h", bus.Pc_Plus4, 32'hC); end
  endtask

  task automatic test_branch_jalr();
    bus.PcSrc = 2'b01;
    bus.Imm   = 32'hFFFF_FFF8;
    #1;
    checks++; if (bus.Next_Address !== 32'h0 || bus.Trap_Taken !== 1'b0) begin errors++;
      $display("FAIL branch_next: got %h t=%b want 0 t=0", bus.Next_Address, bus.Trap_Taken); end
    tick();
    checks++; if (bus.Current_pc !== 32'h0) begin errors++;
      $display("FAIL branch_pc: got %h want %h", bus.Current_pc, 32'h0); end
    bus.PcSrc      = 2'b10;
    bus.ALU_Output = 32'h21;
    #1;
    checks++; if (bus.Next_Address !== 32'h20) begin errors++;
      $display("FAIL jalr_next: got %h want %h", bus.Next_Address, 32'h20); end
    tick();
    checks++; if (bus.Current_pc !== 32'h20) begin errors++;
      $display("FAIL jalr_pc: got %h want %h", bus.Current_pc, 32'h20); end
  endtask

  task automatic test_misaligned();
    bus.PcSrc      = 2'b10;
    bus.ALU_Output = 32'h10;
    tick();
    checks++; if (bus.Current_pc !== 32'h10) begin errors++;
      $display("FAIL mis_setup: got %h want %h", bus.Current_pc, 32'h10); end
    bus.ALU_Output = 32'h22;
    #1;
    checks++; if (bus.Trap_Taken !== 1'b1 || bus.Next_Address !== 32'h100) begin errors++;
      $display("FAIL mis_taken: got t=%b n=%h want t=1 n=100", bus.Trap_Taken,
               bus.Next_Address); end
    tick();
    checks++; if (bus.Current_pc !== 32'h100 || bus.Pc_Valid !== 1'b1) begin errors++;
      $display("FAIL mis_vec: got pc=%h v=%b want 100 v=1", bus.Current_pc, bus.Pc_Valid); end
    checks++; if (bus.Mepc !== 32'h10 || bus.Mcause !== 4'd0 || bus.Mtval !== 32'h22) begin
      errors++;
      $display("FAIL mis_mregs: got %h %h %h want 10 0 22", bus.Mepc, bus.Mcause, bus.Mtval); end
    bus.PcSrc = 2'b11;
    #1;
    checks++; if (bus.Next_Address !== 32'h10) begin errors++;
      $display("FAIL mret_next: got %h want %h", bus.Next_Address, 32'h10); end
    tick();
    checks++; if (bus.Current_pc !== 32'h10) begin errors++;
      $display("FAIL mret_pc: got %h want %h", bus.Current_pc, 32'h10); end
    // Back in RUN, a second mret is just PC+4.
    #1;
    checks++; if (bus.Next_Address !== 32'h14 || bus.Trap_Taken !== 1'b0) begin errors++;
      $display("FAIL mret_run: got %h t=%b want 14 t=0", bus.Next_Address, bus.Trap_Taken); end
    tick();
  endtask

  task automatic test_priority();
    bus.PcSrc      = 2'b01;
    bus.Imm        = 32'h2;
    bus.Trap_Req   = 1'b1;
    bus.Trap_Cause = 4'd11;
    #1;
    checks++; if (bus.Trap_Taken !== 1'b1) begin errors++;
      $display("FAIL prio_taken: got %b want 1", bus.Trap_Taken); end
    tick();
    checks++; if (bus.Current_pc !== 32'h100 || bus.Mepc !== 32'h14) begin errors++;
      $display("FAIL prio_pc: got pc=%h mepc=%h want 100 14", bus.Current_pc, bus.Mepc); end
    checks++; if (bus.Mcause !== 4'd11 || bus.Mtval !== 32'h0) begin errors++;
      $display("FAIL prio_cause: got %h %h want b 0", bus.Mcause, bus.Mtval); end
  endtask

  task automatic test_halt();
    bus.PcSrc      = 2'b00;
    bus.Trap_Req   = 1'b1;
    bus.Trap_Cause = 4'd2;
    #1;
    checks++; if (bus.Trap_Taken !== 1'b1 || bus.Next_Address !== 32'h100) begin errors++;
      $display("FAIL nest_taken: got t=%b n=%h want 1 100", bus.Trap_Taken, bus.Next_Address); end
    tick();
    checks++; if (bus.Halted !== 1'b1 || bus.Pc_Valid !== 1'b0) begin errors++;
      $display("FAIL halt_flags: got h=%b v=%b want 1 0", bus.Halted, bus.Pc_Valid); end
    checks++; if (bus.Mepc !== 32'h100 || bus.Mcause !== 4'd2 || bus.Mtval !== 32'h0) begin
      errors++;
      $display("FAIL halt_mregs: got %h %h %h want 100 2 0", bus.Mepc, bus.Mcause, bus.Mtval); end
    bus.PcSrc      = 2'b10;
    bus.ALU_Output = 32'h40;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.Trap_Taken !== 1'b0) begin errors++;
        $display("FAIL halt_trap%0d: got %b want 0", i, bus.Trap_Taken); end
      tick();
      checks++; if (bus.Current_pc !== 32'h100 || bus.Halted !== 1'b1) begin errors++;
        $display("FAIL halt_hold%0d: got pc=%h h=%b want 100 1", i, bus.Current_pc,
                 bus.Halted); end
    end
    reset = 1'b1;
    tick();
    checks++; if (bus.Current_pc !== 32'h0 || bus.Halted !== 1'b0 || bus.Pc_Valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset: got pc=%h h=%b v=%b want 0 0 0", bus.Current_pc, bus.Halted,
               bus.Pc_Valid); end
    checks++; if (bus.Mepc !== 32'h0 || bus.Mcause !== 4'd0) begin errors++;
      $display("FAIL halt_reset_m: got %h %h want 0 0", bus.Mepc, bus.Mcause); end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_stall();
    tick();
    tick();
    checks++; if (bus.Current_pc !== 32'h4) begin errors++;
      $display("FAIL stall_setup: got %h want %h", bus.Current_pc, 32'h4); end
    bus.Stall      = 1'b1;
    bus.PcSrc      = 2'b01;
    bus.Imm        = 32'h40;
    bus.Trap_Req   = 1'b1;
    bus.Trap_Cause = 4'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.Trap_Taken !== 1'b0 || bus.Next_Address !== 32'h4) begin errors++;
        $display("FAIL stall_comb%0d: got t=%b n=%h want 0 4", i, bus.Trap_Taken,
                 bus.Next_Address); end
      tick();
      checks++; if (bus.Current_pc !== 32'h4 || bus.Mepc !== 32'h0 || bus.Mcause !== 4'd0) begin
        errors++;
        $display("FAIL stall_hold%0d: got pc=%h mepc=%h mc=%h want 4 0 0", i, bus.Current_pc,
                 bus.Mepc, bus.Mcause); end
    end
    bus.Stall = 1'b0;
    #1;
    checks++; if (bus.Trap_Taken !== 1'b1) begin errors++;
      $display("FAIL stall_release: got %b want 1", bus.Trap_Taken); end
    tick();
    checks++; if (bus.Current_pc !== 32'h100 || bus.Mepc !== 32'h4 || bus.Mcause !== 4'd3) begin
      errors++;
      $display("FAIL stall_trap: got pc=%h mepc=%h mc=%h want 100 4 3", bus.Current_pc,
               bus.Mepc, bus.Mcause); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.PcSrc = 2'b01;
    bus.Imm   = 32'hFFFF_FFFC;
    tick();
    checks++; if (bus.Current_pc !== 32'hFFFF_FFFC) begin errors++;
      $display("FAIL wrap_pc: got %h want %h", bus.Current_pc, 32'hFFFF_FFFC); end
    bus.PcSrc = 2'b00;
    #1;
    checks++; if (bus.Pc_Plus4 !== 32'h0 || bus.Next_Address !== 32'h0) begin errors++;
      $display("FAIL wrap_plus4: got %h %h want 0 0", bus.Pc_Plus4, bus.Next_Address); end
    tick();
    checks++; if (bus.Current_pc !== 32'h0) begin errors++;
      $display("FAIL wrap_next: got %h want %h", bus.Current_pc, 32'h0); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_branch_jalr();
    test_misaligned();
    test_priority();
    test_halt();
    test_stall();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
